// File: rtl/spi_master_seq.sv
// -----------------------------------------------------------------------------
// spi_master_seq -- SPI mode-0 master sequencer.
//
// Sends a multi-byte message under a single ssel assertion. sck is derived from
// clk with a programmable half-period (DIV). tx bytes are shifted out MSB-first
// and rx bytes are assembled from miso. Setup, hold and inter-message gap
// timing are enforced so that a slave with input synchronisers sees clean edges.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   start, len       message request (sampled in IDLE) and length in bytes
//   tx_data/valid    host byte stream; tx_ready marks the consuming cycle
//   rx_data/valid    received byte and its one-cycle strobe
//   busy, done       message in progress / one-cycle end-of-message pulse
//   sck, mosi, miso  SPI bus; ssel is the active-low slave select
// -----------------------------------------------------------------------------
module spi_master_seq #(
  parameter int DIV       = 4,  // sck half-period in clk cycles (>=2)
  parameter int SETUP_CYC = 4,  // ssel fall to LOAD, in clk cycles
  parameter int GAP_CYC   = 8   // ssel high time before done
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       ssel
);

  localparam int CNT_MAX0 = (DIV > SETUP_CYC) ? DIV : SETUP_CYC;
  localparam int CNT_MAX  = (CNT_MAX0 > GAP_CYC) ? CNT_MAX0 : GAP_CYC;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_LOW, S_HIGH, S_HOLD, S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;           // phase counter, reused by every timed state
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [7:0]    shift_q, shift_d;       // tx byte being serialised
  logic [7:0]    rx_shift_q, rx_shift_d; // rx byte being assembled
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          ssel_q, ssel_d;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bitcnt_d    = bitcnt_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    ssel_d      = ssel_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // done_q blocks a start that arrives in the same cycle as done.
        if (start && (len != 8'd0) && !done_q) begin
          remaining_d = len;
          ssel_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        if (tx_valid) begin
          shift_d  = tx_data;
          mosi_d   = tx_data[7];
          bitcnt_d = 3'd0;
          state_d  = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d      = '0;
          sck_d      = 1'b1;
          // miso is captured on the same edge that raises sck.
          rx_shift_d = {rx_shift_q[6:0], miso};
          state_d    = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          sck_d = 1'b0;
          if (bitcnt_q != 3'd7) begin
            shift_d  = {shift_q[6:0], 1'b0};
            mosi_d   = shift_q[6];
            bitcnt_d = bitcnt_q + 3'd1;
            state_d  = S_LOW;
          end else begin
            rx_data_d   = rx_shift_q;
            rx_valid_d  = 1'b1;
            remaining_d = remaining_q - 8'd1;
            state_d     = (remaining_q > 8'd1) ? S_LOAD : S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          ssel_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= 3'd0;
      remaining_q <= 8'd0;
      shift_q     <= 8'd0;
      rx_shift_q  <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      ssel_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      ssel_q      <= ssel_d;
    end
  end

  // tx_ready is the only combinational output: it must rise in the cycle LOAD
  // is entered so the handshake costs a single LOAD cycle.
  assign tx_ready = (state_q == S_LOAD);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign ssel     = ssel_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_master_seq -- self-checking bench for spi_master_seq.
//
// A behavioural mode-0 SPI slave returns random bytes on miso and records what
// it receives on mosi. A negedge monitor records bus events (edges, strobes,
// handshakes) as cycle stamps. Each test task drives one scenario and compares
// the recorded events against what the SPI framing rules require.
// -----------------------------------------------------------------------------
module tb_spi_master_seq;

  localparam int DIV       = 4;
  localparam int SETUP_CYC = 4;
  localparam int GAP_CYC   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       miso = 1'b0;
  logic       tx_ready, rx_valid, busy, done, sck, mosi, ssel;
  logic [7:0] rx_data;

  spi_master_seq #(.DIV(DIV), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .sck(sck), .mosi(mosi), .miso(miso), .ssel(ssel)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- behavioural SPI slave (mode 0) ----------------
  logic [7:0] slave_tx_q[$];   // bytes the slave completed sending
  logic [7:0] slave_rx_q[$];   // bytes the slave completed receiving
  logic [7:0] s_tx, s_rx;
  int         s_bit;
  bit         s_active = 1'b0;
  logic       s_prev_sck = 1'b0;

  always @(ssel or sck) begin
    if (ssel) begin
      s_active = 1'b0;
    end else if (!s_active) begin
      s_active = 1'b1;
      s_bit    = 0;
      s_tx     = 8'($urandom);
      miso     = s_tx[7];
    end else if (sck && !s_prev_sck) begin
      s_rx = {s_rx[6:0], mosi};
      s_bit++;
      if (s_bit == 8) begin
        slave_rx_q.push_back(s_rx);
        slave_tx_q.push_back(s_tx);
        s_bit = 0;
        s_tx  = 8'($urandom);
      end
    end else if (!sck && s_prev_sck) begin
      miso = s_tx[7 - s_bit];
    end
    s_prev_sck = sck;
  end

  // ---------------- bus monitor ----------------
  int ssel_falls = 0, ssel_rises = 0, sck_rises = 0, done_cnt = 0;
  int per_bad = 0, mosi_bad = 0, sck_hi_bad = 0, pulse_bad = 0;
  int fall_cyc = 0, first_rise_cyc = 0, last_rise_cyc = 0, rises_in_msg = 0;
  int ssel_rise_cyc = 0, done_cyc = 0;
  logic [7:0] rx_got[$];
  int hs_cyc[$], rxv_cyc[$];
  logic p_ssel = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, p_hs = 1'b0, p_rxv = 1'b0, p_done = 1'b0;

  always @(negedge clk) begin
    if (p_ssel && !ssel) begin ssel_falls++; fall_cyc = cyc; rises_in_msg = 0; end
    if (!p_ssel && ssel) begin ssel_rises++; ssel_rise_cyc = cyc; end
    if (!p_sck && sck) begin
      sck_rises++;
      if (rises_in_msg == 0) first_rise_cyc = cyc;
      else if ((rises_in_msg % 8) != 0 && (cyc - last_rise_cyc) != 2 * DIV) per_bad++;
      last_rise_cyc = cyc;
      rises_in_msg++;
    end
    if (ssel && sck) sck_hi_bad++;
    if (rst_n && (mosi !== p_mosi) && !(p_sck && !sck) && !p_hs) mosi_bad++;
    if (tx_ready && tx_valid) hs_cyc.push_back(cyc + 1);
    if (rx_valid) begin rx_got.push_back(rx_data); rxv_cyc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if ((rx_valid && p_rxv) || (done && p_done)) pulse_bad++;
    p_ssel = ssel; p_sck = sck; p_mosi = mosi; p_hs = tx_ready && tx_valid;
    p_rxv = rx_valid; p_done = done;
  end

  typedef struct {
    int falls, rises, sckr, dn, per, mb, hi, pulse, rxn, stn, srn, hsn, rvn;
  } snap_t;

  function automatic snap_t take_snap();
    snap_t s;
    s.falls = ssel_falls; s.rises = ssel_rises; s.sckr = sck_rises; s.dn = done_cnt;
    s.per = per_bad; s.mb = mosi_bad; s.hi = sck_hi_bad; s.pulse = pulse_bad;
    s.rxn = rx_got.size(); s.stn = slave_tx_q.size(); s.srn = slave_rx_q.size();
    s.hsn = hs_cyc.size(); s.rvn = rxv_cyc.size();
    return s;
  endfunction

  // Message plan consumed by run_msg: byte values and underrun wait per byte.
  logic [7:0] plan_data[$];
  int         plan_wait[$];

  // mode 0: normal start; mode 1: start driven in the done cycle (must be
  // ignored, then accepted one cycle later); mode 2: extra start while busy.
  task automatic run_msg(input int mode);
    snap_t s0, s1;
    int n, t, ub;
    n  = plan_data.size();
    ub = 0;
    s0 = take_snap();
    if (mode == 1) begin
      start = 1'b1; len = 8'(n);
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || ssel !== 1'b1)
        begin errors++; $display("FAIL start_in_done_cycle: busy=%b ssel=%b, required busy=0 ssel=1", busy, ssel); end
      @(posedge clk); #1; start = 1'b0;
    end else begin
      @(posedge clk); #1; start = 1'b1; len = 8'(n);
      @(posedge clk); #1; start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || ssel !== 1'b0)
      begin errors++; $display("FAIL accept: busy=%b ssel=%b, required busy=1 ssel=0", busy, ssel); end

    for (int i = 0; i < n; i++) begin
      t = 0;
      while (tx_ready !== 1'b1 && t < 500) begin @(posedge clk); #1; t++; end
      if (tx_ready !== 1'b1)
        begin checks++; errors++; $display("FAIL tx_ready_timeout: byte %0d never requested", i); end
      for (int w = 0; w < plan_wait[i]; w++) begin
        @(posedge clk); #1;
        if (sck !== 1'b0 || ssel !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b1) ub++;
      end
      tx_valid = 1'b1; tx_data = plan_data[i];
      @(posedge clk); #1; tx_valid = 1'b0;
      if (mode == 2 && i == 0) begin
        start = 1'b1; len = 8'd9;
        @(posedge clk); #1; start = 1'b0;
      end
    end

    t = 0;
    while (done !== 1'b1 && t < 4000) begin @(negedge clk); t++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_timeout: no done within %0d cycles", t); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b required 0", busy); end
    #1;
    s1 = take_snap();

    checks++;
    if (s1.falls - s0.falls != 1 || s1.rises - s0.rises != 1)
      begin errors++; $display("FAIL ssel_edges: falls=%0d rises=%0d required 1/1", s1.falls - s0.falls, s1.rises - s0.rises); end
    checks++;
    if (s1.sckr - s0.sckr != 8 * n)
      begin errors++; $display("FAIL sck_pulses: got %0d required %0d", s1.sckr - s0.sckr, 8 * n); end
    checks++;
    if (s1.dn - s0.dn != 1) begin errors++; $display("FAIL done_count: got %0d required 1", s1.dn - s0.dn); end
    checks++;
    if (done_cyc - ssel_rise_cyc != GAP_CYC)
      begin errors++; $display("FAIL gap_time: got %0d required %0d", done_cyc - ssel_rise_cyc, GAP_CYC); end
    checks++;
    if (s1.per != s0.per || s1.mb != s0.mb || s1.hi != s0.hi || s1.pulse != s0.pulse)
      begin errors++; $display("FAIL bus_rules: period=%0d mosi=%0d sck_ssel_hi=%0d pulse=%0d required all 0",
                               s1.per - s0.per, s1.mb - s0.mb, s1.hi - s0.hi, s1.pulse - s0.pulse); end
    checks++;
    if (ub != 0) begin errors++; $display("FAIL underrun_idle: %0d bad cycles, required 0", ub); end
    if (plan_wait[0] == 0) begin
      checks++;
      if (first_rise_cyc - fall_cyc != SETUP_CYC + 1 + DIV)
        begin errors++; $display("FAIL setup_time: got %0d required %0d", first_rise_cyc - fall_cyc, SETUP_CYC + 1 + DIV); end
    end
    checks++;
    if (s1.rxn - s0.rxn != n || s1.stn - s0.stn != n || s1.srn - s0.srn != n ||
        s1.hsn - s0.hsn != n || s1.rvn - s0.rvn != n) begin
      errors++;
      $display("FAIL byte_counts: rx=%0d slave_tx=%0d slave_rx=%0d hs=%0d rxv=%0d required %0d",
               s1.rxn - s0.rxn, s1.stn - s0.stn, s1.srn - s0.srn, s1.hsn - s0.hsn, s1.rvn - s0.rvn, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rx_got[s0.rxn + i] !== slave_tx_q[s0.stn + i])
          begin errors++; $display("FAIL rx_byte[%0d]: got %02h required %02h", i, rx_got[s0.rxn + i], slave_tx_q[s0.stn + i]); end
        checks++;
        if (slave_rx_q[s0.srn + i] !== plan_data[i])
          begin errors++; $display("FAIL mosi_byte[%0d]: got %02h required %02h", i, slave_rx_q[s0.srn + i], plan_data[i]); end
        checks++;
        if (rxv_cyc[s0.rvn + i] - hs_cyc[s0.hsn + i] != 16 * DIV)
          begin errors++; $display("FAIL byte_time[%0d]: got %0d required %0d", i, rxv_cyc[s0.rvn + i] - hs_cyc[s0.hsn + i], 16 * DIV); end
      end
    end
  endtask

  task automatic test_reset();
    snap_t s0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ssel !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0)
      begin errors++; $display("FAIL reset_bus: ssel=%b sck=%b mosi=%b required 1/0/0", ssel, sck, mosi); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 1'b0)
      begin errors++; $display("FAIL reset_status: busy=%b done=%b rx_valid=%b tx_ready=%b required 0", busy, done, rx_valid, tx_ready); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %02h required 00", rx_data); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s0 = take_snap();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ssel !== 1'b1 || sck !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_idle: ssel=%b sck=%b busy=%b required 1/0/0", ssel, sck, busy); end
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != s0.dn || rx_got.size() != s0.rxn || ssel_falls != s0.falls)
      begin errors++; $display("FAIL reset_no_pulses: done=%0d rx=%0d falls=%0d required 0", done_cnt - s0.dn, rx_got.size() - s0.rxn, ssel_falls - s0.falls); end
  endtask

  task automatic test_single();
    plan_data = '{8'hA5}; plan_wait = '{0};
    run_msg(0);
  endtask

  task automatic test_multi();
    plan_data = '{8'h01, 8'h02, 8'h02}; plan_wait = '{0, 0, 0};
    run_msg(0);
  endtask

  task automatic test_underrun();
    plan_data = '{8'($urandom), 8'($urandom)}; plan_wait = '{0, 20};
    run_msg(0);
  endtask

  task automatic test_ignored_starts();
    snap_t s0;
    s0 = take_snap();
    @(posedge clk); #1; start = 1'b1; len = 8'd0;
    @(posedge clk); #1; start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (ssel_falls != s0.falls || done_cnt != s0.dn || busy !== 1'b0)
      begin errors++; $display("FAIL len0_ignored: falls=%0d done=%0d busy=%b required 0/0/0", ssel_falls - s0.falls, done_cnt - s0.dn, busy); end
    plan_data = '{8'($urandom), 8'($urandom)}; plan_wait = '{0, 0};
    run_msg(2);
  endtask

  task automatic test_back_to_back();
    plan_data = '{8'($urandom)}; plan_wait = '{0};
    run_msg(0);
    plan_data = '{8'($urandom), 8'($urandom)}; plan_wait = '{0, 1};
    run_msg(1);
  endtask

  task automatic test_random();
    int n;
    for (int m = 0; m < 5; m++) begin
      n = $urandom_range(1, 4);
      plan_data.delete(); plan_wait.delete();
      for (int i = 0; i < n; i++) begin
        plan_data.push_back(8'($urandom));
        plan_wait.push_back((i == 0) ? 0 : int'($urandom_range(0, 3)));
      end
      run_msg(0);
    end
  endtask

  task automatic test_reset_mid_byte();
    snap_t s0;
    int t;
    s0 = take_snap();
    @(posedge clk); #1; start = 1'b1; len = 8'd1;
    @(posedge clk); #1; start = 1'b0;
    t = 0;
    while (tx_ready !== 1'b1 && t < 500) begin @(posedge clk); #1; t++; end
    tx_valid = 1'b1; tx_data = 8'($urandom);
    @(posedge clk); #1; tx_valid = 1'b0;
    t = 0;
    while (sck_rises - s0.sckr < 5 && t < 500) begin @(posedge clk); #1; t++; end
    checks++;
    if (sck_rises - s0.sckr != 5 || sck !== 1'b1)
      begin errors++; $display("FAIL mid_byte_reach: rises=%0d sck=%b required 5/1", sck_rises - s0.sckr, sck); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ssel !== 1'b1 || sck !== 1'b0 || busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00)
      begin errors++; $display("FAIL mid_byte_reset: ssel=%b sck=%b busy=%b rx_valid=%b rx_data=%02h required 1/0/0/0/00",
                               ssel, sck, busy, rx_valid, rx_data); end
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rx_got.size() != s0.rxn || done_cnt != s0.dn || slave_rx_q.size() != s0.srn)
      begin errors++; $display("FAIL mid_byte_no_rx: rx=%0d done=%0d slave_rx=%0d required 0", rx_got.size() - s0.rxn, done_cnt - s0.dn, slave_rx_q.size() - s0.srn); end
    plan_data = '{8'($urandom)}; plan_wait = '{0};
    run_msg(0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_underrun();
    test_ignored_starts();
    test_back_to_back();
    test_random();
    test_reset_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- SPI mode-0 master sequencer for the board bench; drives the SPI slave model (sck/mosi/miso/ssel) from a simple host-side byte interface.
- Frames a multi-byte message under one ssel assertion, generates sck from clk via a programmable divider, serialises tx bytes MSB-first and captures rx bytes.
- Enforces the setup, hold and inter-message gap timing the slave's synchronisers need.

Parameters:
- DIV, 4, sck half-period in clk cycles; legal range ≥2; must be ≥4 when driving the synchronised slave model.
- SETUP_CYC, 4, clk cycles from ssel falling to the first sck activity.
- GAP_CYC, 8, minimum clk cycles ssel stays high after a message before done/idle.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a message; sampled only in IDLE
- len  in  8  message length in bytes, latched on accepted start; 0 means start is ignored
- tx_data  in  8  next byte to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  byte consumed this cycle (tx_valid && tx_ready = transfer)
- rx_data  out  8  last received byte, held until the next rx_valid
- rx_valid  out  1  one-cycle pulse when rx_data updates
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at message end
- sck  out  1  SPI clock, idle low
- mosi  out  1  master data out
- miso  in  1  slave data in
- ssel  out  1  slave select, active low

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ssel=1, sck=0, mosi=0.
  - tx_ready=0, rx_valid=0, done=0, busy=0, rx_data=0x00.
  - Takes effect immediately, including mid-byte; no partial rx_valid is issued.
- All outputs are registered except tx_ready, which is decoded combinationally as (state==LOAD).
- IDLE:
  - start && len!=0: latch remaining=len; next cycle ssel=0, busy=1 → SETUP.
  - start with len==0: ignored.
  - start in any other state: ignored.
- SETUP: hold ssel=0, sck=0 for SETUP_CYC cycles → LOAD.
- LOAD:
  - tx_ready=1; wait for tx_valid.
  - On handshake: shift_reg=tx_data, mosi=tx_data[7], bitcnt=0 → LOW.
  - Underrun (tx_valid=0): stay in LOAD with sck=0 and ssel=0 indefinitely.
- LOW: sck=0 for DIV cycles; on expiry sck←1 and miso is sampled into rx_shift in the same cycle → HIGH.
- HIGH: sck=1 for DIV cycles; on expiry sck←0, then:
  - bitcnt<7: shift left, mosi=next bit, bitcnt+1 → LOW.
  - bitcnt==7: rx_data=rx_shift, rx_valid pulse, remaining−1.
    - remaining was >1 → LOAD.
    - remaining was 1 → HOLD.
- Byte timing: one byte = 16·DIV clk cycles from handshake to rx_valid (+1 LOAD cycle minimum between bytes).
- HOLD: sck=0 for DIV cycles; then ssel←1 → GAP.
- GAP: ssel=1 for GAP_CYC cycles; then done pulse, busy←0 → IDLE.
  - A start in the same cycle as done is ignored; the next start is accepted one cycle later.
- Counters:
  - Phase counter width clog2(max(DIV,SETUP_CYC,GAP_CYC)+1).
  - remaining is 8-bit; len=255 gives 255 bytes; no wrap.
- ssel has exactly one falling and one rising edge per message; sck never toggles while ssel=1.
- mosi changes only on sck falling transitions or at the LOAD handshake (sck low).

Test Plan:
- Reset: assert rst_n=0 mid-idle → ssel=1, sck=0, busy=0, rx_data=0x00; no pulses on done/rx_valid.
- First message after reset, len=1, tx 0xA5, DIV=4 → 8 sck pulses, period 8 clk; rx_data=0x00 with one rx_valid; slave LED=1; done pulse GAP_CYC cycles after ssel rises.
- Second message, len=3, tx 0x01,0x02,0x02:
  - ssel low continuously across all 3 bytes; single ssel falling edge.
  - rx_data sequence 0x01,0x00,0x00.
  - slave LED=0 after byte 3.
- Underrun: len=2; hold tx_valid=0 for 20 cycles before byte 2 → sck stays 0, ssel stays 0, busy=1; on tx_valid, byte 2 completes correctly with 16·DIV timing.
- Ignored starts: start with len=0 → no ssel edge, no done; start pulse while busy → no effect on byte count or timing.
- Reset mid-byte (bit 4 of byte 1) → ssel=1, sck=0 immediately, no rx_valid; next len=1 message completes and returns the slave's incremented message count as its rx byte.
